// File: rtl/pixel_plotter.sv
// pixel_plotter: buffers drawer pixel requests, clips and linearises them into
// framebuffer writes, and runs a full-screen clear sweep on request.
module pixel_plotter #(
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int COORD_W    = 11,
  parameter int ADDR_W     = 19,
  parameter int COLOR_W    = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               px_valid,
  output logic               px_ready,
  input  logic [COORD_W-1:0] px_x,
  input  logic [COORD_W-1:0] px_y,
  input  logic [COLOR_W-1:0] px_color,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  output logic               busy,
  output logic               dropped,
  output logic               clear_done,
  output logic               fb_we,
  output logic [ADDR_W-1:0]  fb_addr,
  output logic [COLOR_W-1:0] fb_wdata,
  input  logic               fb_grant,
  output logic [1:0]         dbg_state
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = ADDR_W + COLOR_W;

  localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(V_RES);
  localparam logic [ADDR_W-1:0]  H_MUL     = ADDR_W'(H_RES);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PLOT  = 2'd1;
  localparam logic [1:0] S_CLEAR = 2'd2;

  // Handshake: a request transfers on the clk edge where px_valid & px_ready are both
  // high; px_ready depends only on flops, so drawers may hold px_valid until it rises.

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic               fb_we_q, fb_we_d;
  logic [ADDR_W-1:0]  fb_addr_q, fb_addr_d;
  logic [COLOR_W-1:0] fb_wdata_q, fb_wdata_d;
  logic               clear_pending_q, clear_pending_d;
  logic [COLOR_W-1:0] clear_color_q, clear_color_d;
  logic               dropped_q, dropped_d;
  logic               init_q, init_d;

  logic               fifo_empty;
  logic               fifo_full;
  logic               on_screen;
  logic               accept;
  logic               push;
  logic               pop;
  logic               out_free;
  logic               start_clear;
  logic               clear_take;
  logic [ADDR_W-1:0]  px_addr;
  logic [ENTRY_W-1:0] head;

  // Pointer-only ring: one slot always stays unused, so it holds FIFO_DEPTH-1 entries.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = ((wr_ptr_q + PTR_W'(1)) == rd_ptr_q);
  assign head       = mem_q[rd_ptr_q];

  assign on_screen = (px_x < X_LIM) && (px_y < Y_LIM);
  assign px_addr   = ADDR_W'(px_y) * H_MUL + ADDR_W'(px_x);

  assign px_ready   = init_q & ~fifo_full & ~clear_pending_q & (state_q != S_CLEAR);
  assign accept     = px_valid & px_ready;
  assign push       = accept & on_screen;
  assign out_free   = ~fb_we_q | fb_grant;
  assign clear_take = clear_req & ~clear_pending_q & (state_q != S_CLEAR);

  always_comb begin
    state_d         = state_q;
    wr_ptr_d        = wr_ptr_q;
    rd_ptr_d        = rd_ptr_q;
    fb_we_d         = fb_we_q;
    fb_addr_d       = fb_addr_q;
    fb_wdata_d      = fb_wdata_q;
    clear_pending_d = clear_pending_q;
    clear_color_d   = clear_color_q;
    dropped_d       = accept & ~on_screen;
    init_d          = 1'b1;
    pop             = 1'b0;
    start_clear     = 1'b0;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_PLOT;
        end else if (clear_pending_q) begin
          start_clear = 1'b1;
        end
      end
      S_PLOT: begin
        if (out_free) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else if (clear_pending_q) begin
            start_clear = 1'b1;
          end else begin
            fb_we_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_CLEAR: begin
        // The sweep address only moves on granted cycles, so no location is skipped.
        if (fb_grant) begin
          if (fb_addr_q == LAST_ADDR) begin
            fb_we_d = 1'b0;
            state_d = S_IDLE;
          end else begin
            fb_addr_d = fb_addr_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        fb_we_d = 1'b0;
      end
    endcase

    if (pop) begin
      rd_ptr_d                = rd_ptr_q + PTR_W'(1);
      {fb_addr_d, fb_wdata_d} = head;
      fb_we_d                 = 1'b1;
    end

    if (start_clear) begin
      state_d         = S_CLEAR;
      fb_we_d         = 1'b1;
      fb_addr_d       = '0;
      fb_wdata_d      = clear_color_q;
      clear_pending_d = 1'b0;
    end

    if (clear_take) begin
      clear_pending_d = 1'b1;
      clear_color_d   = clear_color;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fb_we_q         <= 1'b0;
      fb_addr_q       <= '0;
      fb_wdata_q      <= '0;
      clear_pending_q <= 1'b0;
      clear_color_q   <= '0;
      dropped_q       <= 1'b0;
      init_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      fb_we_q         <= fb_we_d;
      fb_addr_q       <= fb_addr_d;
      fb_wdata_q      <= fb_wdata_d;
      clear_pending_q <= clear_pending_d;
      clear_color_q   <= clear_color_d;
      dropped_q       <= dropped_d;
      init_q          <= init_d;
    end
  end

  // Storage needs no reset: entries are only read between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {px_addr, px_color};
    end
  end

  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_wdata   = fb_wdata_q;
  assign dropped    = dropped_q;
  assign clear_done = (state_q == S_CLEAR) & fb_we_q & fb_grant & (fb_addr_q == LAST_ADDR);
  assign busy       = clear_pending_q | (state_q != S_IDLE) | ~fifo_empty | fb_we_q;
  assign dbg_state  = state_q;

endmodule
